// File: rtl/sirv_gnrl_sync_fifo_if.sv
// Valid/ready handshake bundle for the generic sync FIFO.
// slave = FIFO side, master = surrounding producer/consumer.
interface sirv_gnrl_sync_fifo_if #(
    parameter int DW = 32
);
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;

    modport slave (
        input  i_vld,
        input  i_dat,
        output i_rdy,
        output o_vld,
        output o_dat,
        input  o_rdy
    );

    modport master (
        output i_vld,
        output i_dat,
        input  i_rdy,
        input  o_vld,
        input  o_dat,
        output o_rdy
    );
endinterface

// File: rtl/sirv_gnrl_sync_fifo.sv
// Synchronous valid/ready FIFO with wrap-flag pointers.
// Storage entries are plain load-enabled registers with no reset.
module sirv_gnrl_sync_fifo #(
    parameter int DW = 32,
    parameter int DP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sirv_gnrl_sync_fifo_if.slave     bus,
    output logic [$clog2(DP):0]      fifo_cnt
);
    localparam int AW = $clog2(DP);

    logic [DW-1:0] r_mem [DP];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [AW:0]   r_cnt;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_wptr_nxt;
    logic [AW:0]   w_rptr_nxt;

    // MSB of each pointer is the wrap flag
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0])
                   & (r_wptr[AW] != r_rptr[AW]);

    assign w_push = bus.i_vld & ~w_full;
    assign w_pop  = bus.o_rdy & ~w_empty;

    assign w_wptr_nxt = w_push ? r_wptr + 1'b1 : r_wptr;
    assign w_rptr_nxt = w_pop  ? r_rptr + 1'b1 : r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cnt  <= w_wptr_nxt - w_rptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.i_dat;
        end
    end

    // Ready and valid come from registered state only
    assign bus.i_rdy = ~w_full;
    assign bus.o_vld = ~w_empty;
    assign bus.o_dat = r_mem[r_rptr[AW-1:0]];
    assign fifo_cnt  = r_cnt;

endmodule

// File: tb/tb_sirv_gnrl_sync_fifo.sv
// Directed and random checks of sirv_gnrl_sync_fifo against a queue model.
module tb_sirv_gnrl_sync_fifo;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] fifo_cnt;

    sirv_gnrl_sync_fifo_if #(.DW(DW)) bus ();

    sirv_gnrl_sync_fifo #(.DW(DW), .DP(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [DW-1:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_vld", 64'(bus.o_vld), 64'(q.size() != 0));
        chk("i_rdy", 64'(bus.i_rdy), 64'(q.size() < DP));
        chk("cnt", 64'(fifo_cnt), 64'(q.size()));
        if (q.size() != 0)
            chk("o_dat", 64'(bus.o_dat), 64'(q[0]));
    endtask

    // Called at a negedge; applies one cycle and checks at the next negedge
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic r, output logic acc);
        logic psh;
        logic pp;
        bus.i_vld = v;
        bus.i_dat = d;
        bus.o_rdy = r;
        @(posedge clk);
        psh = v && (q.size() < DP);
        pp  = r && (q.size() != 0);
        if (pp) void'(q.pop_front());
        if (psh) q.push_back(d);
        acc = psh;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic acc;
        logic cv;
        logic [DW-1:0] cd;
        bus.i_vld = 1'b0;
        bus.i_dat = '0;
        bus.o_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // 1: single push, no flow-through
        step(1'b1, 32'hA5A5_0001, 1'b0, acc);
        chk("t1_acc", 64'(acc), 64'd1);
        step(1'b0, '0, 1'b1, acc);

        // 2: fill, refuse 5th, drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 32'(16 + i), 1'b0, acc);
        chk("t2_full_cnt", 64'(fifo_cnt), 64'd4);
        step(1'b1, 32'h14, 1'b0, acc);
        chk("t2_refused", 64'(acc), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_head", 64'(bus.o_dat), 64'(16 + i));
            step(1'b0, '0, 1'b1, acc);
        end
        chk("t2_empty", 64'(bus.o_vld), 64'd0);

        // 3: full with push+pop together -> only pop
        for (int i = 0; i < 4; i++) step(1'b1, 32'(16 + i), 1'b0, acc);
        step(1'b1, 32'h14, 1'b1, acc);
        chk("t3_refused", 64'(acc), 64'd0);
        chk("t3_cnt", 64'(fifo_cnt), 64'd3);
        step(1'b1, 32'h14, 1'b0, acc);
        chk("t3_accept", 64'(acc), 64'd1);
        while (q.size() != 0) step(1'b0, '0, 1'b1, acc);

        // 4: steady push+pop at depth 2, pointers wrap
        step(1'b1, 32'hF0, 1'b0, acc);
        step(1'b1, 32'hF1, 1'b0, acc);
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i), 1'b1, acc);
        chk("t4_cnt", 64'(fifo_cnt), 64'd2);
        while (q.size() != 0) step(1'b0, '0, 1'b1, acc);

        // 5: pop on empty is ignored
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, acc);
        chk("t5_cnt", 64'(fifo_cnt), 64'd0);

        // 6: async reset mid-cycle
        for (int i = 0; i < 3; i++) step(1'b1, 32'(32 + i), 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vld", 64'(bus.o_vld), 64'd0);
        chk("t6_cnt", 64'(fifo_cnt), 64'd0);
        q.delete();
        bus.i_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h55, 1'b0, acc);
        chk("t6_first", 64'(bus.o_dat), 64'h55);
        step(1'b0, '0, 1'b1, acc);

        // Random traffic honouring the hold-until-accepted rule
        cv = 1'b0;
        cd = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!cv) begin
                cv = 1'($urandom_range(0, 1));
                cd = $urandom;
            end
            step(cv, cd, 1'($urandom_range(0, 1)), acc);
            if (acc) cv = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
